// File: rtl/uart_cmd_comm.sv
// uart_cmd_comm: 8N1 UART front end; three RX bytes form a 24-bit command, single response bytes go out on TX.
// Optional inter-byte timeout on partial commands when CMD_TIMEOUT_EN is defined.
module uart_cmd_comm #(
    parameter int BAUD_DIV     = 2604,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic        resp_sent
);
    localparam logic [15:0] FULL = 16'(BAUD_DIV);
    localparam logic [15:0] HALF = 16'(BAUD_DIV / 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      rx_state, rx_next, tx_state, tx_next;
    logic        rx_s1, rx_s2, rx_prev;
    logic [15:0] rx_cnt, tx_cnt;
    logic [2:0]  rx_bit, tx_bit;
    logic [7:0]  rx_shift, tx_shift;
    logic        rx_exp, tx_exp, rx_vld, rx_err, take, set_rdy, timeout, tx_load;
    logic [1:0]  byte_cnt;

    assign rx_exp  = rx_cnt == 16'd1;
    assign tx_exp  = tx_cnt == 16'd1;
    assign take    = rx_vld && !cmd_rdy;
    assign set_rdy = take && byte_cnt == 2'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {rx_s1, rx_s2, rx_prev} <= 3'b111;
        else        {rx_s1, rx_s2, rx_prev} <= {RX, rx_s1, rx_s2};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (rx_prev && !rx_s2) rx_next = START;
            START: if (rx_exp) rx_next = rx_s2 ? IDLE : DATA;
            DATA:  if (rx_exp && rx_bit == 3'd7) rx_next = STOP;
            STOP:  if (rx_exp) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    // Counter idles at HALF so the start bit is re-checked mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt   <= HALF;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
            rx_vld   <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_cnt   <= rx_state == IDLE ? HALF : rx_exp ? FULL : rx_cnt - 16'd1;
            rx_bit   <= rx_state != DATA ? 3'd0 : rx_exp ? rx_bit + 3'd1 : rx_bit;
            rx_shift <= (rx_state == DATA && rx_exp) ? {rx_s2, rx_shift[7:1]} : rx_shift;
            rx_vld   <= rx_state == STOP && rx_exp && rx_s2;
            rx_err   <= rx_state == STOP && rx_exp && !rx_s2;
        end
    end

`ifdef CMD_TIMEOUT_EN
    localparam logic [31:0] LIMIT = 32'(TIMEOUT_BITS * BAUD_DIV);
    logic [31:0] idle_cnt;
    logic        idle_run;
    assign idle_run = byte_cnt != 2'd0 && rx_state == IDLE && !rx_vld;
    assign timeout  = idle_run && idle_cnt == LIMIT - 32'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_cnt <= 32'd0;
        else        idle_cnt <= idle_run ? idle_cnt + 32'd1 : 32'd0;
    end
`else
    assign timeout = TIMEOUT_BITS < 0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd      <= 24'd0;
            cmd_rdy  <= 1'b0;
            byte_cnt <= 2'd0;
        end else begin
            if (take)
                cmd <= {byte_cnt == 2'd0 ? rx_shift : cmd[23:16],
                        byte_cnt == 2'd1 ? rx_shift : cmd[15:8],
                        byte_cnt == 2'd2 ? rx_shift : cmd[7:0]};
            cmd_rdy  <= set_rdy || (cmd_rdy && !clr_cmd_rdy);
            byte_cnt <= rx_err ? 2'd0 : take ? (set_rdy ? 2'd0 : byte_cnt + 2'd1) : timeout ? 2'd0 : byte_cnt;
        end
    end

    assign tx_load   = send_resp && (tx_state == IDLE || (tx_state == STOP && tx_exp));
    assign resp_sent = tx_state == STOP && tx_exp;
    assign TX        = tx_state == START ? 1'b0 : tx_state == DATA ? tx_shift[0] : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            IDLE:  if (send_resp) tx_next = START;
            START: if (tx_exp) tx_next = DATA;
            DATA:  if (tx_exp && tx_bit == 3'd7) tx_next = STOP;
            STOP:  if (tx_exp) tx_next = send_resp ? START : IDLE;
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt   <= FULL;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
        end else begin
            tx_cnt   <= (tx_state == IDLE || tx_exp) ? FULL : tx_cnt - 16'd1;
            tx_bit   <= tx_state != DATA ? 3'd0 : tx_exp ? tx_bit + 3'd1 : tx_bit;
            tx_shift <= tx_load ? resp_data : (tx_state == DATA && tx_exp) ? {1'b0, tx_shift[7:1]} : tx_shift;
        end
    end
endmodule

// File: tb/tb_uart_cmd_comm.sv
// tb_uart_cmd_comm: directed bench for uart_cmd_comm with BAUD_DIV=16, TIMEOUT_BITS=4.
module tb_uart_cmd_comm;
    logic        clk = 1'b0, rst_n = 1'b0, rx_line = 1'b1, loop = 1'b0;
    logic        clr_cmd_rdy = 1'b0, send_resp = 1'b0;
    logic [7:0]  resp_data = 8'h00;
    logic        TX, cmd_rdy, resp_sent, rx, e;
    logic [23:0] cmd;
    logic [7:0]  c3 = 8'hC3, tx_cap;
    int          n_cmp = 0, n_bad = 0, rs_cnt, rs_at;

    assign rx = loop ? TX : rx_line;
    always #5 clk = ~clk;

    uart_cmd_comm #(.BAUD_DIV(16), .TIMEOUT_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .RX(rx), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data), .send_resp(send_resp), .resp_sent(resp_sent)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; frame bits last 16 clocks; 'timed' checks the cmd_rdy rise edge.
    task automatic send_byte(input logic [7:0] d, input logic sb, input logic timed);
        logic [9:0] f;
        f = {sb, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_line = f[i];
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                if (timed && i == 9 && j == 10) chk("rdy_before_rise", cmd_rdy, 0);
                if (timed && i == 9 && j == 11) chk("rdy_rise", cmd_rdy, 1);
            end
        end
        rx_line = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx", TX, 1);
        chk("rst_cmd", cmd, 0);
        chk("rst_rdy", cmd_rdy, 0);
        chk("rst_sent", resp_sent, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send_byte(8'h02, 1, 0); send_byte(8'h1A, 1, 0); send_byte(8'h3C, 1, 1);
        chk("cmd1", cmd, 24'h021A3C);

        send_byte(8'h55, 1, 0); send_byte(8'h66, 1, 0); send_byte(8'h77, 1, 0);
        chk("drop_cmd", cmd, 24'h021A3C);
        chk("drop_rdy", cmd_rdy, 1);
        pulse_clr();
        chk("clr_rdy", cmd_rdy, 0);
        chk("clr_cmd", cmd, 24'h021A3C);

        clr_cmd_rdy = 1'b1;
        send_byte(8'h01, 1, 0); send_byte(8'h02, 1, 0); send_byte(8'h03, 1, 1);
        clr_cmd_rdy = 1'b0;
        chk("cmd2", cmd, 24'h010203);
        chk("cmd2_rdy_cleared", cmd_rdy, 0);

        rx_line = 1'b0;
        repeat (4) @(negedge clk);
        rx_line = 1'b1;
        repeat (170) @(negedge clk);
        chk("glitch_rdy", cmd_rdy, 0);
        chk("glitch_cmd", cmd, 24'h010203);
        send_byte(8'hAB, 1, 0); send_byte(8'hCD, 1, 0); send_byte(8'hEF, 1, 0);
        chk("cmd3", cmd, 24'hABCDEF);
        chk("cmd3_rdy", cmd_rdy, 1);
        pulse_clr();

        send_byte(8'h5A, 1, 0); send_byte(8'hA5, 0, 0);
        send_byte(8'h12, 1, 0); send_byte(8'h34, 1, 0); send_byte(8'h56, 1, 0);
        chk("ferr_cmd", cmd, 24'h123456);
        chk("ferr_rdy", cmd_rdy, 1);
        pulse_clr();

        resp_data = 8'hC3;
        send_resp = 1'b1;
        rs_cnt = 0;
        rs_at = 0;
        for (int n = 1; n <= 175; n++) begin
            @(negedge clk);
            e = n <= 16 ? 1'b0 : n <= 144 ? c3[(n - 17) / 16] : 1'b1;
            chk("tx_line", TX, e);
            if (resp_sent) begin
                rs_cnt++;
                rs_at = n;
            end
            if (n == 1) send_resp = 1'b0;
            if (n == 50) begin
                send_resp = 1'b1;
                resp_data = 8'h00;
            end
            if (n == 51) send_resp = 1'b0;
        end
        chk("resp_sent_count", rs_cnt, 1);
        chk("resp_sent_cycle", rs_at, 160);

        fork
            begin
                send_byte(8'h11, 1, 0);
                send_byte(8'h22, 1, 0);
            end
            begin
                resp_data = 8'h99;
                send_resp = 1'b1;
                tx_cap = 8'h00;
                rs_cnt = 0;
                for (int n = 1; n <= 170; n++) begin
                    @(negedge clk);
                    if (n == 1) send_resp = 1'b0;
                    if (n >= 24 && n <= 136 && (n - 24) % 16 == 0) tx_cap[(n - 24) / 16] = TX;
                    if (resp_sent) rs_cnt++;
                end
            end
        join
        chk("duplex_tx_byte", tx_cap, 8'h99);
        chk("duplex_sent", rs_cnt, 1);
        chk("duplex_partial_cmd", cmd, 24'h112256);
        chk("duplex_rdy", cmd_rdy, 0);

        loop = 1'b1;
        resp_data = 8'h99;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (180) @(negedge clk);
        loop = 1'b0;
        chk("loop_cmd", cmd, 24'h112299);
        chk("loop_rdy", cmd_rdy, 1);
        pulse_clr();

        send_byte(8'h10, 1, 0);
        repeat (80) @(negedge clk);
        send_byte(8'h20, 1, 0); send_byte(8'h30, 1, 0); send_byte(8'h40, 1, 0);
`ifdef CMD_TIMEOUT_EN
        chk("timeout_cmd", cmd, 24'h203040);
`else
        chk("no_timeout_cmd", cmd, 24'h102030);
`endif
        chk("timeout_rdy", cmd_rdy, 1);

        resp_data = 8'hC3;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (4) @(negedge clk);
        chk("midframe_tx_low", TX, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", TX, 1);
        chk("async_rst_cmd", cmd, 0);
        chk("async_rst_rdy", cmd_rdy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_cmd_comm.md
Name: uart_cmd_comm

Overview:
- Host-side serial front end of the scope digital core.
- Receives 8N1 UART bytes on RX and assembles three consecutive bytes into the 24-bit command consumed by the core (cmd / cmd_rdy / clr_cmd_rdy).
- Serialises single response bytes from the core back to the host on TX (resp_data / send_resp / resp_sent).
- Contains its own RX and TX bit engines; no FIFO.

Parameters:
- BAUD_DIV, 2604: clk cycles per bit (19200 baud at 50 MHz). Legal range 16..65535.
- TIMEOUT_BITS, 32: inter-byte gap limit in bit-times. Used only with CMD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- RX  in  1  serial in from host, asynchronous, idle high
- TX  out  1  serial out to host, idle high
- cmd  out  24  assembled command; byte0 in [23:16], byte1 in [15:8], byte2 in [7:0]
- cmd_rdy  out  1  level; cmd is valid and stable
- clr_cmd_rdy  in  1  one-cycle pulse from core; consumes the command
- resp_data  in  8  response byte, sampled on send_resp
- send_resp  in  1  one-cycle pulse; start transmission
- resp_sent  out  1  one-cycle pulse; response stop bit completed

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock.
- Reset values: TX=1, cmd=0, cmd_rdy=0, resp_sent=0; byte count=0; RX and TX FSMs in IDLE.
- RX synchroniser: two flops, each preset to 1. Start is detected on a 1->0 transition of the synchronised RX.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE->START on a detected falling edge; load baud counter with BAUD_DIV/2.
  - START: at count expiry, if synced RX=1 it is a false start -> IDLE. Otherwise -> DATA with counter = BAUD_DIV.
  - DATA: sample once per BAUD_DIV clocks, 8 bits, LSB first, shifted right into an 8-bit shift register.
  - STOP: sample after BAUD_DIV clocks. 1 = byte valid; 0 = framing error. Then -> IDLE either way.
- Byte assembly:
  - On a valid byte with cmd_rdy=0, write it into the cmd slot given by the byte count (0,1,2) and increment the count.
  - When the count reaches 3: cmd_rdy=1 on the clock after the third stop sample; count returns to 0.
  - Valid bytes arriving while cmd_rdy=1 are dropped. cmd is not modified and the count is not changed.
  - Framing error: discard the byte and reset the count to 0. A held cmd and cmd_rdy are untouched.
- cmd_rdy clear:
  - clr_cmd_rdy=1 clears cmd_rdy on the next clock. cmd keeps its value.
  - If clr_cmd_rdy coincides with the cycle setting cmd_rdy, set wins.
- TX FSM states: IDLE, START, DATA, STOP.
  - send_resp in IDLE latches resp_data. TX drives 0 from the next clock.
  - Frame: start bit, 8 data bits LSB first, stop bit (1); each bit BAUD_DIV clocks.
  - resp_sent pulses for 1 clock on the cycle the stop bit period ends. The FSM returns to IDLE in that same cycle.
  - send_resp while not IDLE is ignored. send_resp in the same cycle as resp_sent is accepted.
- RX and TX are fully independent; full-duplex operation is allowed.
- Reset mid-frame: everything returns to reset values immediately. TX goes high asynchronously.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - An idle counter runs while 0 < byte count < 3 and the RX FSM is IDLE.
  - After TIMEOUT_BITS*BAUD_DIV clocks with no new start bit, the byte count resets to 0 and the partial command is abandoned. cmd holds stale partial bytes; cmd_rdy stays 0.
  - The counter restarts on each accepted byte.
- Undefined: no timeout exists. A partial command waits indefinitely for its remaining bytes.

Test Plan (bench uses BAUD_DIV=16, TIMEOUT_BITS=4):
- Host sends 0x02, 0x1A, 0x3C -> cmd_rdy rises 1 clk after the third stop sample with cmd=0x021A3C. Pulse clr_cmd_rdy -> cmd_rdy=0 next clk, cmd unchanged.
- With cmd_rdy=1, host sends 0x55, 0x66, 0x77 -> cmd stays 0x021A3C. Then clr, then send 0x01, 0x02, 0x03 -> cmd=0x010203.
- 0.25-bit low glitch on RX -> no byte accepted, count stays 0. Byte 0xA5 with stop bit=0 after one good byte -> count resets to 0; the next 3 good bytes form cmd.
- send_resp with resp_data=0xC3 -> TX=0 for 16 clks, then bits 1,1,0,0,0,0,1,1, then 1 for 16 clks. resp_sent pulses exactly once, 160 clks after send_resp. A second send_resp at clk 50 is ignored.
- Loopback TX->RX: host bytes 0x11, 0x22 sent concurrently with response 0x99 -> both directions complete correctly.
- CMD_TIMEOUT_EN: send 0x10, wait 80 clks, send 0x20, 0x30, 0x40 -> cmd=0x203040. Without the macro, the same stimulus gives cmd=0x102030.
